// File: rtl/cpu_loader_if.sv
// cpu_loader_if: bundles the host control/stream signals and the cpu external memory
// ports that cpu_loader drives.
//   master  - cpu_loader side: drives s_ready, m_valid/m_data, busy/done, cpu reset/enable
//             and the instruction/data memory strobes.
//   slave   - environment side (host, cpu memories): drives start/config, s_valid/s_data,
//             m_ready and rdata_ext_2.
interface cpu_loader_if #(
  parameter int unsigned CNT_W = 32
);
  // Session control and configuration (sampled on start)
  logic             start;
  logic [7:0]       n_instr;
  logic [7:0]       n_data;
  logic [CNT_W-1:0] run_cycles;
  logic [7:0]       n_dump;
  // Load stream
  logic             s_valid;
  logic             s_ready;
  logic [63:0]      s_data;
  // Dump stream
  logic             m_valid;
  logic             m_ready;
  logic [63:0]      m_data;
  // Status and core control
  logic             busy;
  logic             done;
  logic             cpu_arst_n;
  logic             cpu_enable;
  // Instruction memory port
  logic [63:0]      addr_ext;
  logic             wen_ext;
  logic             ren_ext;
  logic [31:0]      wdata_ext;
  // Data memory port
  logic [63:0]      addr_ext_2;
  logic             wen_ext_2;
  logic             ren_ext_2;
  logic [63:0]      wdata_ext_2;
  logic [63:0]      rdata_ext_2;

  modport master (
    input  start, n_instr, n_data, run_cycles, n_dump,
    input  s_valid, s_data, m_ready, rdata_ext_2,
    output s_ready, m_valid, m_data, busy, done, cpu_arst_n, cpu_enable,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output start, n_instr, n_data, run_cycles, n_dump,
    output s_valid, s_data, m_ready, rdata_ext_2,
    input  s_ready, m_valid, m_data, busy, done, cpu_arst_n, cpu_enable,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/cpu_loader.sv
// cpu_loader: sole master of the cpu external memory ports. A session loads a program into
// instruction memory, an image into data memory, runs the core for a programmed number of
// cycles, then streams a data-memory dump back to the host.
// Ports:
//   clk    - clock
//   arst_n - active-low reset, sampled synchronously on clk
//   bus    - cpu_loader_if.master: start/config, load stream (s_*), dump stream (m_*),
//            busy/done, cpu_arst_n/cpu_enable and both external memory ports
module cpu_loader #(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 128,
  parameter int unsigned CNT_W      = 32
) (
  input  logic          clk,
  input  logic          arst_n,
  cpu_loader_if.master  bus
);

  localparam logic [7:0] ImemMax = 8'(IMEM_WORDS);
  localparam logic [7:0] DmemMax = 8'(DMEM_WORDS);

  typedef enum logic [2:0] {
    StIdle, StLoadI, StLoadD, StRun, StDumpRd, StDumpWt, StDumpOut
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       ni_q, ni_d;
  logic [7:0]       nd_q, nd_d;
  logic [7:0]       nk_q, nk_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [63:0]      mdata_q, mdata_d;
  logic             done_q, done_d;

  logic [7:0] ni_in, nd_in, nk_in;

  // First phase with work left after 'prev' finishes; phases run in fixed order.
  function automatic state_e phase_after(input state_e prev, input logic [7:0] ni,
                                         input logic [7:0] nd, input logic run_nz,
                                         input logic [7:0] nk);
    state_e s;
    s = StIdle;
    if (nk != 8'd0) s = StDumpRd;
    if (run_nz && prev != StRun) s = StRun;
    if (nd != 8'd0 && (prev == StIdle || prev == StLoadI)) s = StLoadD;
    if (ni != 8'd0 && prev == StIdle) s = StLoadI;
    return s;
  endfunction

  always_comb begin
    ni_in = (bus.n_instr > ImemMax) ? ImemMax : bus.n_instr;
    nd_in = (bus.n_data  > DmemMax) ? DmemMax : bus.n_data;
    nk_in = (bus.n_dump  > DmemMax) ? DmemMax : bus.n_dump;
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    ni_d            = ni_q;
    nd_d            = nd_q;
    nk_d            = nk_q;
    run_d           = run_q;
    mdata_d         = mdata_q;
    bus.s_ready     = 1'b0;
    bus.m_valid     = 1'b0;
    bus.cpu_enable  = 1'b0;
    bus.addr_ext    = '0;
    bus.wen_ext     = 1'b0;
    bus.ren_ext     = 1'b0;
    bus.wdata_ext   = '0;
    bus.addr_ext_2  = '0;
    bus.wen_ext_2   = 1'b0;
    bus.ren_ext_2   = 1'b0;
    bus.wdata_ext_2 = '0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          ni_d    = ni_in;
          nd_d    = nd_in;
          nk_d    = nk_in;
          run_d   = bus.run_cycles;
          idx_d   = 8'd0;
          state_d = phase_after(StIdle, ni_in, nd_in, bus.run_cycles != '0, nk_in);
        end
      end
      StLoadI: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          bus.wen_ext   = 1'b1;
          bus.addr_ext  = {54'd0, idx_q, 2'b00};
          bus.wdata_ext = bus.s_data[31:0];
          if (idx_q == ni_q - 8'd1) begin
            idx_d   = 8'd0;
            state_d = phase_after(StLoadI, ni_q, nd_q, run_q != '0, nk_q);
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StLoadD: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          bus.wen_ext_2   = 1'b1;
          bus.addr_ext_2  = {53'd0, idx_q, 3'b000};
          bus.wdata_ext_2 = bus.s_data;
          if (idx_q == nd_q - 8'd1) begin
            idx_d   = 8'd0;
            state_d = phase_after(StLoadD, ni_q, nd_q, run_q != '0, nk_q);
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StRun: begin
        // Only entered with run_q != 0, so enable is high exactly run_cycles cycles.
        bus.cpu_enable = 1'b1;
        run_d          = run_q - CNT_W'(1);
        if (run_q == CNT_W'(1)) begin
          state_d = phase_after(StRun, ni_q, nd_q, 1'b0, nk_q);
        end
      end
      StDumpRd: begin
        bus.ren_ext_2  = 1'b1;
        bus.addr_ext_2 = {53'd0, idx_q, 3'b000};
        state_d        = StDumpWt;
      end
      StDumpWt: begin
        // Read data arrives the cycle after ren_ext_2.
        mdata_d = bus.rdata_ext_2;
        state_d = StDumpOut;
      end
      StDumpOut: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) begin
          if (idx_q == nk_q - 8'd1) begin
            idx_d   = 8'd0;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StDumpRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pulse on any return to IDLE, including an all-zero session that never leaves it.
    done_d = (state_d == StIdle) && (state_q != StIdle || bus.start);
  end

  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.done       = done_q;
    bus.m_data     = mdata_q;
    bus.cpu_arst_n = (state_q == StRun) || (state_q == StDumpRd) ||
                     (state_q == StDumpWt) || (state_q == StDumpOut);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= StIdle;
      idx_q   <= 8'd0;
      ni_q    <= 8'd0;
      nd_q    <= 8'd0;
      nk_q    <= 8'd0;
      run_q   <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ni_q    <= ni_d;
      nd_q    <= nd_d;
      nk_q    <= nk_d;
      run_q   <= run_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// tb_cpu_loader: directed bench for cpu_loader with a small data-memory model behind the
// data port (one-cycle read latency).
module tb_cpu_loader;

  logic clk;
  logic arst_n;
  int   tests = 0;
  int   fails = 0;

  cpu_loader_if #(.CNT_W(32)) bus ();

  cpu_loader #(
    .IMEM_WORDS (128),
    .DMEM_WORDS (128),
    .CNT_W      (32)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  logic [63:0] mem [0:127];

  always @(posedge clk) begin
    if (bus.wen_ext_2) mem[bus.addr_ext_2[9:3]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= mem[bus.addr_ext_2[9:3]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given config; returns one cycle later, inputs not yet settled.
  task automatic start_session(input logic [7:0] ni, input logic [7:0] nd,
                               input logic [31:0] rc, input logic [7:0] nk);
    bus.n_instr    = ni;
    bus.n_data     = nd;
    bus.run_cycles = rc;
    bus.n_dump     = nk;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int beat;
    arst_n          = 1'b0;
    bus.start       = 1'b0;
    bus.n_instr     = '0;
    bus.n_data      = '0;
    bus.run_cycles  = '0;
    bus.n_dump      = '0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.m_ready     = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cpu_arst_n", bus.cpu_arst_n, 0);
    chk("rst_cpu_enable", bus.cpu_enable, 0);
    chk("rst_wen_ext", bus.wen_ext, 0);
    chk("rst_ren_ext", bus.ren_ext, 0);
    chk("rst_wen_ext_2", bus.wen_ext_2, 0);
    chk("rst_ren_ext_2", bus.ren_ext_2, 0);
    chk("rst_addr_ext", bus.addr_ext, 0);
    chk("rst_addr_ext_2", bus.addr_ext_2, 0);
    chk("rst_wdata_ext", bus.wdata_ext, 0);
    chk("rst_wdata_ext_2", bus.wdata_ext_2, 0);
    arst_n = 1'b1;
    tick();

    // 4 instructions then 2 data words back to back, no gap
    start_session(8'd4, 8'd2, 32'd0, 8'd0);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = 64'hDEAD_0000_0000_0010 + 64'(i);
      #1;
      chk("li_wen", bus.wen_ext, 1);
      chk("li_addr", bus.addr_ext, 64'(4 * i));
      chk("li_wdata", bus.wdata_ext, 64'h10 + 64'(i));
      chk("li_wen2", bus.wen_ext_2, 0);
      chk("li_cpu_rst", bus.cpu_arst_n, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      bus.s_data = 64'hCAFE_0000_0000_0020 + 64'(i);
      #1;
      chk("ld_wen2", bus.wen_ext_2, 1);
      chk("ld_addr2", bus.addr_ext_2, 64'(8 * i));
      chk("ld_wdata2", bus.wdata_ext_2, 64'hCAFE_0000_0000_0020 + 64'(i));
      chk("ld_wen", bus.wen_ext, 0);
      tick();
    end
    bus.s_valid = 1'b0;
    #1;
    chk("load_done", bus.done, 1);
    chk("load_busy", bus.busy, 0);
    chk("load_wen2_off", bus.wen_ext_2, 0);
    tick();
    chk("load_done_1cyc", bus.done, 0);

    // s_valid toggling while loading 3 instructions
    start_session(8'd3, 8'd0, 32'd0, 8'd0);
    beat = 0;
    for (int c = 0; c < 5; c++) begin
      bus.s_valid = (c % 2 == 0);
      bus.s_data  = 64'h100 + 64'(c);
      #1;
      chk("tog_wen", bus.wen_ext, (c % 2 == 0) ? 64'd1 : 64'd0);
      chk("tog_busy", bus.busy, 1);
      if (c % 2 == 0) begin
        chk("tog_addr", bus.addr_ext, 64'(4 * beat));
        beat++;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    #1;
    chk("tog_done", bus.done, 1);
    tick();

    // Run only, with a start pulse during RUN that must be ignored
    #1;
    chk("run_pre_rst", bus.cpu_arst_n, 0);
    start_session(8'd0, 8'd0, 32'd10, 8'd0);
    for (int c = 0; c < 10; c++) begin
      bus.start      = (c == 3);
      bus.n_instr    = 8'd5;
      bus.run_cycles = 32'd3;
      #1;
      chk("run_en", bus.cpu_enable, 1);
      chk("run_cpu_rst", bus.cpu_arst_n, 1);
      chk("run_s_ready", bus.s_ready, 0);
      chk("run_busy", bus.busy, 1);
      tick();
    end
    bus.start      = 1'b0;
    bus.n_instr    = 8'd0;
    bus.run_cycles = 32'd0;
    #1;
    chk("run_en_off", bus.cpu_enable, 0);
    chk("run_done", bus.done, 1);
    chk("run_busy_off", bus.busy, 0);
    chk("run_cpu_rst_off", bus.cpu_arst_n, 0);
    tick();
    chk("run_done_1cyc", bus.done, 0);
    chk("run_idle_s_ready", bus.s_ready, 0);

    // All-zero config
    start_session(8'd0, 8'd0, 32'd0, 8'd0);
    #1;
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.busy, 0);
    chk("zero_wen", bus.wen_ext, 0);
    chk("zero_wen2", bus.wen_ext_2, 0);
    chk("zero_ren2", bus.ren_ext_2, 0);
    chk("zero_en", bus.cpu_enable, 0);
    tick();
    chk("zero_done_1cyc", bus.done, 0);

    // Load 0xA,0xB,0xC, run 2 cycles, dump 3 words with a stall on word 2
    start_session(8'd0, 8'd3, 32'd2, 8'd3);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = 64'hA + 64'(i);
      #1;
      chk("dl_wen2", bus.wen_ext_2, 1);
      chk("dl_addr2", bus.addr_ext_2, 64'(8 * i));
      chk("dl_cpu_rst", bus.cpu_arst_n, 0);
      tick();
    end
    bus.s_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("dr_en", bus.cpu_enable, 1);
      chk("dr_cpu_rst", bus.cpu_arst_n, 1);
      tick();
    end
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("dp_ren2", bus.ren_ext_2, 1);
      chk("dp_addr2", bus.addr_ext_2, 64'(8 * w));
      chk("dp_en_off", bus.cpu_enable, 0);
      chk("dp_mvalid_rd", bus.m_valid, 0);
      tick();
      chk("dp_ren2_wt", bus.ren_ext_2, 0);
      chk("dp_mvalid_wt", bus.m_valid, 0);
      tick();
      if (w == 1) begin
        for (int s = 0; s < 5; s++) begin
          bus.m_ready = 1'b0;
          #1;
          chk("dp_stall_valid", bus.m_valid, 1);
          chk("dp_stall_data", bus.m_data, 64'hB);
          tick();
        end
      end
      bus.m_ready = 1'b1;
      #1;
      chk("dp_valid", bus.m_valid, 1);
      chk("dp_data", bus.m_data, 64'hA + 64'(w));
      chk("dp_cpu_rst", bus.cpu_arst_n, 1);
      tick();
      bus.m_ready = 1'b0;
    end
    #1;
    chk("dp_done", bus.done, 1);
    chk("dp_busy", bus.busy, 0);
    chk("dp_mvalid_off", bus.m_valid, 0);
    chk("dp_cpu_rst_off", bus.cpu_arst_n, 0);
    tick();

    // Instruction count above depth clamps to 128 words
    start_session(8'd200, 8'd0, 32'd0, 8'd0);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      bus.s_data = 64'(i);
      #1;
      chk("cl_wen", bus.wen_ext, 1);
      chk("cl_addr", bus.addr_ext, 64'(4 * i));
      tick();
    end
    #1;
    chk("cl_no_extra", bus.wen_ext, 0);
    chk("cl_done", bus.done, 1);
    bus.s_valid = 1'b0;
    tick();

    // Reset during LOAD_D after 3 beats
    start_session(8'd0, 8'd8, 32'd5, 8'd0);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = 64'h55 + 64'(i);
      #1;
      chk("ra_wen2", bus.wen_ext_2, 1);
      tick();
    end
    arst_n = 1'b0;
    tick();
    chk("ra_busy", bus.busy, 0);
    chk("ra_wen2_off", bus.wen_ext_2, 0);
    chk("ra_s_ready", bus.s_ready, 0);
    chk("ra_cpu_rst", bus.cpu_arst_n, 0);
    chk("ra_done", bus.done, 0);
    arst_n      = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    chk("ra_done_after", bus.done, 0);
    chk("ra_busy_after", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_loader.md
Name: cpu_loader

Overview:
- Host-side front end that sits directly upstream of the cpu top and drives its external memory ports.
- Streams a program into instruction memory (addr_ext/wen_ext/wdata_ext) and an initial image into data memory (addr_ext_2/wen_ext_2/wdata_ext_2).
- Then holds the core out of reset, asserts enable for a programmed number of cycles, and streams a data-memory dump back to the host over ren_ext_2/rdata_ext_2.
- Used by the system bench and by the FPGA wrapper as the only master of the cpu external ports.

Parameters:
- IMEM_WORDS, 128, instruction-memory depth in 32-bit words (512 bytes, matches ADDR_W 9).
- DMEM_WORDS, 128, data-memory depth in 64-bit words (1024 bytes, matches ADDR_W 10).
- CNT_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  main clock.
- arst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that launches a session; ignored unless in IDLE.
- n_instr  in  8  instruction words to load (0..IMEM_WORDS), sampled on start.
- n_data  in  8  data words to load (0..DMEM_WORDS), sampled on start.
- run_cycles  in  CNT_W  cycles of cpu_enable high, sampled on start.
- n_dump  in  8  data words to dump from address 0 (0..DMEM_WORDS), sampled on start.
- s_valid  in  1  load stream valid.
- s_ready  out  1  load stream ready.
- s_data  in  64  load word; bits [31:0] are used in the instruction phase.
- m_valid  out  1  dump stream valid.
- m_ready  in  1  dump stream ready.
- m_data  out  64  dump word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on entry to IDLE from DUMP/RUN/LOAD.
- cpu_arst_n  out  1  reset to the cpu core.
- cpu_enable  out  1  enable to the cpu core.
- addr_ext  out  64  byte address, instruction memory.
- wen_ext  out  1  instruction memory write enable.
- ren_ext  out  1  instruction memory read enable; tied 0.
- wdata_ext  out  32  instruction word.
- addr_ext_2  out  64  byte address, data memory.
- wen_ext_2  out  1  data memory write enable.
- ren_ext_2  out  1  data memory read enable.
- wdata_ext_2  out  64  data word.
- rdata_ext_2  in  64  data memory read data; valid one cycle after ren_ext_2.

Behaviour:
- Reset (arst_n=0 at a clk edge): state IDLE; all counters 0.
  - Outputs: s_ready=0, m_valid=0, m_data=0, busy=0, done=0, cpu_arst_n=0, cpu_enable=0.
  - All wen/ren=0; all addr/wdata=0.
  - Reset mid-session aborts immediately; no done pulse is generated.
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WT, DUMP_OUT.
- IDLE:
  - On start, latch the four config inputs.
  - Go to the first phase whose count is nonzero, in order LOAD_I, LOAD_D, RUN, DUMP_RD.
  - If all counts are 0, return to IDLE with a done pulse on the next cycle.
  - Counts above the depth clamp to the depth.
- LOAD_I:
  - s_ready=1.
  - Each cycle with s_valid&s_ready: wen_ext=1 (combinational, same cycle), wdata_ext=s_data[31:0], addr_ext=4*idx.
  - idx then increments.
  - After the n_instr-th beat, advance to the next nonzero phase.
- LOAD_D: same handshake, with wen_ext_2, wdata_ext_2=s_data, addr_ext_2=8*idx; idx restarts at 0.
- No load bubbles: the beat accepted in the last cycle of LOAD_I is followed by a LOAD_D beat possible on the next cycle.
- cpu_arst_n=0 from reset through the end of LOAD_D.
  - It goes 1 on the first RUN cycle, or the first DUMP_RD cycle if RUN is skipped, and stays 1 until return to IDLE.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles, counted by a down-counter, then 0.
  - Next state DUMP_RD, or IDLE if n_dump=0.
  - s_ready=0 and no memory strobes are driven.
- Dump loop (per word):
  - DUMP_RD: ren_ext_2=1, addr_ext_2=8*idx, one cycle.
  - DUMP_WT: capture rdata_ext_2 into m_data.
  - DUMP_OUT: m_valid=1, m_data held stable until m_ready.
  - On the handshake, idx++ and go to DUMP_RD, or IDLE after the n_dump-th word.
  - Throughput is 1 word per 3 cycles minimum; backpressure is unlimited.
- done=1 for exactly the one cycle after the final transition into IDLE; busy falls in that same cycle.
- start while busy: ignored; config is not relatched.
- wen_ext and wen_ext_2 are never high in the same cycle.
- ren_ext is permanently 0; upper address bits are 0.

Test Plan:
- Reset during LOAD_D after 3 beats -> next cycle: IDLE, busy=0, wen_ext_2=0, cpu_arst_n=0, no done pulse.
- n_instr=4, n_data=2, s_valid always 1 -> wen_ext on 4 consecutive cycles at addr 0,4,8,12; wen_ext_2 on the next 2 cycles at addr 0,8; no gap cycle.
- run_cycles=10, all other counts 0 -> cpu_arst_n rises with cpu_enable; cpu_enable high exactly 10 cycles; done pulse one cycle later.
- n_dump=3, memory holds 0xA,0xB,0xC, m_ready low 5 cycles on word 2 -> m_data sequence 0xA,0xB,0xC; word 2 held stable while stalled; ren_ext_2 at addr 0,8,16.
- s_valid toggling 1-0-1 while loading 3 instructions -> exactly 3 writes at 0,4,8; no write in the s_valid=0 cycle.
- start pulsed during RUN, and all-zero config from IDLE -> first: no effect on counts; second: done pulse 1 cycle after start, no strobes.
